// File: rtl/i2s_frame_rx_if.sv
// Frame hand-off bundle between the serial-audio receiver and its consumer.
// Latency: none, this is a wiring bundle only.
// Backpressure: the consumer drives frame_ready, and a transfer happens on a clk edge with frame_valid & frame_ready.
`timescale 1ns/1ps
interface i2s_frame_rx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/i2s_frame_rx.sv
// Oversampling I2S/TDM receiver: deserialises CHANNELS x WIDTH-bit samples into one parallel frame.
// Latency: a bit is sampled 3 clk after its sck rise, and frame_valid rises 4 clk after the final bit's sck rise.
// Backpressure: one frame is buffered in the output register; a frame that completes while it is full is dropped and sets overrun.
`timescale 1ns/1ps
module i2s_frame_rx #(
    parameter int WIDTH     = 16,  // bits kept per channel, MSB first (>= 2)
    parameter int SLOT_BITS = 16,  // sck periods per slot, >= WIDTH
    parameter int CHANNELS  = 2,   // slots per frame (2 for I2S)
    parameter int TDM       = 0    // 0: ws level framing, 1: ws pulse framing
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sck,
    input  logic           ws,
    input  logic           sd,
    input  logic           clr_flags,
    output logic           overrun,
    output logic           sync_err,
    i2s_frame_rx_if.master frm
);
    localparam int FRAME_W = CHANNELS * WIDTH;
    // One extra bit of width so WIDTH itself is representable for the keep test.
    localparam int BIT_W  = $clog2(SLOT_BITS + 1);
    localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BIT_W-1:0]  KEEP_BITS = BIT_W'(WIDTH);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,  // never synchronised since reset
        ST_RX,        // counting bits of a frame
        ST_WAIT       // frame done, waiting for the next frame start
    } state_t;

    state_t             state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic               load_stb;

    logic sck_s1, sck_s2, sck_s3;
    logic ws_s1, ws_s2;
    logic sd_s1, sd_s2;
    logic ws_prev;

    logic               bit_evt;
    logic               frame_start;
    logic               last_bit;
    logic               sync_hit;
    logic               ovr_hit;
    logic               xfer;

    logic [WIDTH-1:0]   chan_buf [CHANNELS];
    logic [FRAME_W-1:0] shift_flat;
    logic [FRAME_W-1:0] data_q;
    logic               valid_q;

    // Two-flop synchronisers on all three pins, plus a third sck flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            ws_s1  <= 1'b0;
            ws_s2  <= 1'b0;
            sd_s1  <= 1'b0;
            sd_s2  <= 1'b0;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            ws_s1  <= ws;
            ws_s2  <= ws_s1;
            sd_s1  <= sd;
            sd_s2  <= sd_s1;
        end
    end

    // ws as seen at the previous bit event, so a falling edge between events can be detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_prev <= 1'b0;
        end else if (bit_evt) begin
            ws_prev <= ws_s2;
        end
    end

    // Event decode: bit strobe, frame start for the selected framing, final bit, flag set causes.
    always_comb begin
        bit_evt     = sck_s2 & ~sck_s3;
        frame_start = 1'b0;
        if (TDM != 0) begin
            frame_start = bit_evt & ws_s2;
        end else begin
            frame_start = bit_evt & ws_prev & ~ws_s2;
        end
        last_bit = (slot_cnt == LAST_SLOT) && (bit_cnt == LAST_BIT);
        // A start on the final bit is the back-to-back case, not an error.
        sync_hit = bit_evt && (state == ST_RX) && frame_start && !last_bit;
        xfer     = valid_q & frm.frame_ready;
        ovr_hit  = load_stb & valid_q & ~frm.frame_ready;
    end

    // Framing state machine: tracks bit/slot position and raises the load strobe on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_UNLOCKED;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            load_stb <= 1'b0;
        end else begin
            load_stb <= 1'b0;
            if (bit_evt) begin
                case (state)
                    ST_UNLOCKED, ST_WAIT: begin
                        if (frame_start) begin
                            state    <= ST_RX;
                            bit_cnt  <= '0;
                            slot_cnt <= '0;
                        end
                    end
                    ST_RX: begin
                        if (last_bit) begin
                            load_stb <= 1'b1;
                            bit_cnt  <= '0;
                            slot_cnt <= '0;
                            state    <= frame_start ? ST_RX : ST_WAIT;
                        end else if (frame_start) begin
                            // Early start: abandon the partial frame and lock onto the new one.
                            bit_cnt  <= '0;
                            slot_cnt <= '0;
                        end else if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            slot_cnt <= slot_cnt + 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_UNLOCKED;
                    end
                endcase
            end
        end
    end

    // Per-channel shift registers; slot bits past WIDTH are not shifted in.
    // Every kept bit is rewritten each frame, so no clearing is needed after an abort.
    always_ff @(posedge clk) begin
        if (bit_evt && (state == ST_RX) && (bit_cnt < KEEP_BITS)) begin
            chan_buf[slot_cnt] <= {chan_buf[slot_cnt][WIDTH-2:0], sd_s2};
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_flat
        assign shift_flat[k*WIDTH +: WIDTH] = chan_buf[k];
    end

    // Output register: load when empty or draining this cycle, otherwise keep the old frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_stb && (!valid_q || frm.frame_ready)) begin
            data_q  <= shift_flat;
            valid_q <= 1'b1;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            overrun  <= (overrun  & ~clr_flags) | ovr_hit;
            sync_err <= (sync_err & ~clr_flags) | sync_hit;
        end
    end

    assign frm.frame_data  = data_q;
    assign frm.frame_valid = valid_q;
endmodule
